// File: rtl/byte_stream_packer.sv
`default_nettype none
// ============================================================================
// Module   : byte_stream_packer
// Purpose  : Packs a byte stream big-endian into 32-bit words for the packet
//            decoder; truncates oversize frames, flags runts, counts frames.
// Revision : 1.0
// ============================================================================
module byte_stream_packer #(
  parameter int MAX_BYTES = 1522,
  parameter int MIN_BYTES = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        rx_last,
  output logic [31:0] packet4_byte,
  output logic        data_valid,
  output logic        last_valid,
  output logic [3:0]  keep,
  output logic        frame_trunc,
  output logic        frame_runt,
  output logic [15:0] frame_cnt
);

  localparam logic [0:0]  S_FILL      = 1'b0;
  localparam logic [0:0]  S_DROP      = 1'b1;
  localparam logic [10:0] c_max_bytes = 11'(MAX_BYTES);
  localparam logic [10:0] c_min_bytes = 11'(MIN_BYTES);

  logic [0:0]  r_state;
  logic [0:0]  w_state_nxt;
  logic [1:0]  r_lane;
  logic [10:0] r_cnt;
  logic [31:0] r_acc;

  logic        w_accept;
  logic [10:0] w_cnt_inc;
  logic        w_at_max;
  logic        w_emit;
  logic        w_end;
  logic        w_trunc;
  logic        w_runt;
  logic [31:0] w_word;
  logic [3:0]  w_keep;

  assign w_accept  = rx_valid && (r_state == S_FILL);
  assign w_cnt_inc = r_cnt + 11'd1;
  assign w_at_max  = (w_cnt_inc == c_max_bytes);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FILL: begin
        if (w_accept && w_at_max && !rx_last) begin
          w_state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (rx_valid && rx_last) begin
          w_state_nxt = S_FILL;
        end
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  // Output decode: word assembly and pulse conditions
  always_comb begin
    w_word = r_acc;
    case (r_lane)
      2'd0:    w_word[31:24] = rx_byte;
      2'd1:    w_word[23:16] = rx_byte;
      2'd2:    w_word[15:8]  = rx_byte;
      default: w_word[7:0]   = rx_byte;
    endcase
    w_keep  = {r_lane == 2'd3, r_lane >= 2'd2, r_lane != 2'd0, 1'b1};
    w_end   = w_accept && (rx_last || w_at_max);
    w_emit  = w_accept && ((r_lane == 2'd3) || rx_last || w_at_max);
    w_trunc = w_end && !rx_last;
    w_runt  = w_accept && rx_last && (w_cnt_inc < c_min_bytes);
  end

  // Accumulator is cleared on emission so unfilled lanes of the next word read 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lane <= 2'd0;
      r_cnt  <= 11'd0;
      r_acc  <= 32'd0;
    end else if (w_accept) begin
      if (w_end) begin
        r_lane <= 2'd0;
        r_cnt  <= 11'd0;
      end else begin
        r_lane <= r_lane + 2'd1;
        r_cnt  <= w_cnt_inc;
      end
      r_acc <= w_emit ? 32'd0 : w_word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      packet4_byte <= 32'd0;
      keep         <= 4'd0;
      data_valid   <= 1'b0;
      last_valid   <= 1'b0;
      frame_trunc  <= 1'b0;
      frame_runt   <= 1'b0;
      frame_cnt    <= 16'd0;
    end else begin
      data_valid  <= w_emit;
      last_valid  <= w_end;
      frame_trunc <= w_trunc;
      frame_runt  <= w_runt;
      if (w_emit) begin
        packet4_byte <= w_word;
        keep         <= w_keep;
      end
      if (w_end) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_byte_stream_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_byte_stream_packer
// Purpose  : Two packer instances (default and 8-byte limit) driven by shared
//            directed and random byte streams, checked against a frame model.
// Revision : 1.0
// ============================================================================
module tb_byte_stream_packer;

  localparam int MIN_B = 14;
  localparam int MAX_A = 1522;
  localparam int MAX_B = 8;

  typedef struct {
    int          inst;
    logic [31:0] w;
    logic [3:0]  k;
    logic        l;
    logic        t;
    logic        r;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_byte = 8'd0;
  logic       rx_valid = 1'b0;
  logic       rx_last = 1'b0;

  logic [31:0] d_word [2];
  logic        d_dv   [2];
  logic        d_lv   [2];
  logic [3:0]  d_keep [2];
  logic        d_tr   [2];
  logic        d_rt   [2];
  logic [15:0] d_cnt  [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  byte_stream_packer #(.MAX_BYTES(MAX_A), .MIN_BYTES(MIN_B)) u_dut_a (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_last(rx_last),
    .packet4_byte(d_word[0]), .data_valid(d_dv[0]), .last_valid(d_lv[0]), .keep(d_keep[0]),
    .frame_trunc(d_tr[0]), .frame_runt(d_rt[0]), .frame_cnt(d_cnt[0])
  );

  byte_stream_packer #(.MAX_BYTES(MAX_B), .MIN_BYTES(MIN_B)) u_dut_b (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_last(rx_last),
    .packet4_byte(d_word[1]), .data_valid(d_dv[1]), .last_valid(d_lv[1]), .keep(d_keep[1]),
    .frame_trunc(d_tr[1]), .frame_runt(d_rt[1]), .frame_cnt(d_cnt[1])
  );

  // Frame-level model: bytes of the current 4-byte group, frame length, drop flag
  int          m_n    [2];
  logic        m_drop [2];
  logic [7:0]  m_grp  [2][4];
  int          m_glen [2];
  logic [31:0] e_word [2];
  logic [3:0]  e_keep [2];
  logic        e_dv   [2];
  logic        e_lv   [2];
  logic        e_tr   [2];
  logic        e_rt   [2];
  logic [15:0] e_cnt  [2];
  ev_t         evlog[$];
  logic        model_live = 1'b0;

  function automatic int max_of(input int i);
    return (i == 0) ? MAX_A : MAX_B;
  endfunction

  task automatic reset_model(input int i);
    m_n[i] = 0; m_drop[i] = 1'b0; m_glen[i] = 0;
    e_word[i] = 32'd0; e_keep[i] = 4'd0; e_dv[i] = 1'b0; e_lv[i] = 1'b0;
    e_tr[i] = 1'b0; e_rt[i] = 1'b0; e_cnt[i] = 16'd0;
  endtask

  task automatic model_step(input int i);
    logic [31:0] w;
    logic        fin;
    ev_t         ev;
    e_dv[i] = 1'b0; e_lv[i] = 1'b0; e_tr[i] = 1'b0; e_rt[i] = 1'b0;
    if (!rx_valid) return;
    if (m_drop[i]) begin
      if (rx_last) m_drop[i] = 1'b0;
      return;
    end
    m_grp[i][m_glen[i]] = rx_byte;
    m_glen[i]++;
    m_n[i]++;
    fin = rx_last || (m_n[i] == max_of(i));
    if (m_glen[i] == 4 || fin) begin
      w = 32'd0;
      for (int j = 0; j < m_glen[i]; j++) w |= 32'(m_grp[i][j]) << (24 - 8 * j);
      e_word[i] = w;
      e_keep[i] = 4'((1 << m_glen[i]) - 1);
      e_dv[i]   = 1'b1;
      if (fin) begin
        e_lv[i] = 1'b1;
        e_cnt[i] = e_cnt[i] + 16'd1;
        e_rt[i] = rx_last && (m_n[i] < MIN_B);
        e_tr[i] = !rx_last;
        m_drop[i] = !rx_last;
        m_n[i] = 0;
      end
      m_glen[i] = 0;
      ev.inst = i; ev.w = e_word[i]; ev.k = e_keep[i];
      ev.l = e_lv[i]; ev.t = e_tr[i]; ev.r = e_rt[i];
      evlog.push_back(ev);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      for (int i = 0; i < 2; i++) begin
        if (!rst) reset_model(i);
        else model_step(i);
      end
      model_live = 1'b1;
    end
  end

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t: got %h want %h", nm, inst, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (model_live) begin
        for (int i = 0; i < 2; i++) begin
          chk("data_valid", i, 32'(d_dv[i]), 32'(e_dv[i]));
          chk("last_valid", i, 32'(d_lv[i]), 32'(e_lv[i]));
          chk("frame_trunc", i, 32'(d_tr[i]), 32'(e_tr[i]));
          chk("frame_runt", i, 32'(d_rt[i]), 32'(e_rt[i]));
          chk("packet4_byte", i, d_word[i], e_word[i]);
          chk("keep", i, 32'(d_keep[i]), 32'(e_keep[i]));
          chk("frame_cnt", i, 32'(d_cnt[i]), 32'(e_cnt[i]));
        end
      end
    end
  end

  // Pin the model itself: nth emitted word of an instance against literals
  task automatic pin(input string nm, input int inst, input int idx, input logic [31:0] w,
                     input logic [3:0] k, input logic l, input logic t, input logic r);
    int   seen = 0;
    logic found = 1'b0;
    ev_t  e;
    e = '{inst: 0, w: 32'd0, k: 4'd0, l: 1'b0, t: 1'b0, r: 1'b0};
    foreach (evlog[j]) begin
      if (evlog[j].inst == inst) begin
        if (seen == idx) begin e = evlog[j]; found = 1'b1; end
        seen++;
      end
    end
    checks++;
    if (!found || e.w !== w || e.k !== k || e.l !== l || e.t !== t || e.r !== r) begin
      errors++;
      $display("FAIL pin %s inst%0d: got found=%0d w=%h k=%b l=%b t=%b r=%b want w=%h k=%b l=%b t=%b r=%b",
               nm, inst, found, e.w, e.k, e.l, e.t, e.r, w, k, l, t, r);
    end
  endtask

  task automatic count_is(input string nm, input int inst, input int exp);
    int n = 0;
    foreach (evlog[j]) if (evlog[j].inst == inst) n++;
    chk(nm, inst, 32'(n), 32'(exp));
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    rx_byte = b; rx_valid = 1'b1; rx_last = last;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_last = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      rx_valid = 1'b0; rx_last = 1'($urandom_range(0, 1)); rx_byte = 8'($urandom);
      @(posedge clk); #1;
    end
    rx_last = 1'b0;
  endtask

  initial begin
    logic [15:0] base;
    int          len;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Short runt frame
    evlog.delete();
    for (int b = 1; b <= 6; b++) send(8'(b), b == 6);
    idle(3);
    count_is("t1_words", 0, 2);
    pin("t1_w0", 0, 0, 32'h01020304, 4'b1111, 1'b0, 1'b0, 1'b0);
    pin("t1_w1", 0, 1, 32'h05060000, 4'b0011, 1'b1, 1'b0, 1'b1);
    pin("t1_w1b", 1, 1, 32'h05060000, 4'b0011, 1'b1, 1'b0, 1'b1);
    chk("t1_cnt", 0, 32'(e_cnt[0]), 32'd1);

    // 64-byte frame with a gap after every byte
    evlog.delete();
    for (int b = 0; b < 64; b++) begin send(8'(b), b == 63); idle(1); end
    idle(3);
    count_is("t2_words", 0, 16);
    pin("t2_w0", 0, 0, 32'h00010203, 4'b1111, 1'b0, 1'b0, 1'b0);
    pin("t2_w15", 0, 15, 32'h3C3D3E3F, 4'b1111, 1'b1, 1'b0, 1'b0);
    pin("t2_trunc", 1, 1, 32'h04050607, 4'b1111, 1'b1, 1'b1, 1'b0);

    // Truncation at the 8-byte limit
    evlog.delete();
    base = e_cnt[1];
    for (int b = 0; b < 10; b++) send(8'h11 + 8'(b), b == 9);
    idle(2);
    count_is("t3_words", 1, 2);
    pin("t3_w0", 1, 0, 32'h11121314, 4'b1111, 1'b0, 1'b0, 1'b0);
    pin("t3_w1", 1, 1, 32'h15161718, 4'b1111, 1'b1, 1'b1, 1'b0);
    chk("t3_cnt", 1, 32'(e_cnt[1] - base), 32'd1);

    // Last byte exactly at the limit
    evlog.delete();
    for (int b = 0; b < 8; b++) send(8'h21 + 8'(b), b == 7);
    idle(2);
    count_is("t4_words", 1, 2);
    pin("t4_w0", 1, 0, 32'h21222324, 4'b1111, 1'b0, 1'b0, 1'b1 & 1'b0);
    pin("t4_w1", 1, 1, 32'h25262728, 4'b1111, 1'b1, 1'b0, 1'b1);

    // Back-to-back frames
    evlog.delete();
    base = e_cnt[0];
    for (int b = 0; b < 15; b++) send(8'hAA, b == 14);
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b1);
    idle(3);
    count_is("t5_words", 0, 5);
    pin("t5_w3", 0, 3, 32'hAAAAAA00, 4'b0111, 1'b1, 1'b0, 1'b0);
    pin("t5_w4", 0, 4, 32'h01020300, 4'b0111, 1'b1, 1'b0, 1'b1);
    pin("t5_b", 1, 2, 32'h01020300, 4'b0111, 1'b1, 1'b0, 1'b1);
    chk("t5_cnt", 0, 32'(e_cnt[0] - base), 32'd2);

    // Reset mid-frame
    for (int b = 0; b < 5; b++) send(8'h90 + 8'(b), 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_word", 0, d_word[0], 32'd0);
    chk("t6_rst_cnt", 0, 32'(d_cnt[0]), 32'd0);
    @(posedge clk); #1;
    idle(2);
    rst = 1'b1;
    @(posedge clk); #1;
    evlog.delete();
    for (int b = 0; b < 16; b++) send(8'h40 + 8'(b), b == 15);
    idle(3);
    count_is("t6_words", 0, 4);
    pin("t6_w0", 0, 0, 32'h40414243, 4'b1111, 1'b0, 1'b0, 1'b0);
    pin("t6_w3", 0, 3, 32'h4C4D4E4F, 4'b1111, 1'b1, 1'b0, 1'b0);
    chk("t6_cnt", 0, 32'(e_cnt[0]), 32'd1);

    // Long frames around the default limit
    evlog.delete();
    for (int b = 0; b < MAX_A; b++) send(8'($urandom), b == MAX_A - 1);
    for (int b = 0; b < MAX_A + 9; b++) send(8'($urandom), b == MAX_A + 8);
    idle(2);
    count_is("long_words", 0, 2 * ((MAX_A + 3) / 4));

    // Random frames with random gaps and stray rx_last
    for (int f = 0; f < 250; f++) begin
      len = $urandom_range(1, 40);
      for (int b = 0; b < len; b++) begin
        send(8'($urandom), b == len - 1);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 4));
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/byte_stream_packer.md
Name: byte_stream_packer

Overview:
- Upstream neighbour of the packet decoder.
- Accepts a byte-wide receive stream, one byte per beat, and packs it big-endian into 32-bit words.
- Drives the decoder's word interface: word data, data_valid, last_valid, keep.
- Enforces a maximum frame length by truncating oversize frames; flags runt frames and counts completed frames.

Parameters:
MAX_BYTES, 1522, maximum forwarded bytes per frame; longer frames are truncated after this byte.
MIN_BYTES, 14, frames shorter than this raise frame_runt; they are still forwarded.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-low reset.
rx_byte  input  8  receive byte.
rx_valid  input  1  rx_byte valid this cycle; always accepted, no backpressure.
rx_last  input  1  final byte of frame; qualified by rx_valid.
packet4_byte  output  32  packed word; first byte of the group in [31:24].
data_valid  output  1  one-cycle pulse per word.
last_valid  output  1  final word of frame; coincides with data_valid.
keep  output  4  valid-byte code, meaningful on the last word.
frame_trunc  output  1  one-cycle pulse with last_valid of a truncated frame.
frame_runt  output  1  one-cycle pulse with last_valid of a frame shorter than MIN_BYTES.
frame_cnt  output  16  completed frames emitted; wraps at 0xFFFF -> 0.

Behaviour:
- Reset (rst low, asynchronous): all outputs 0, lane index 0, byte counter 0, accumulator 0, state FILL.
- Reset mid-frame abandons the frame with no output. The next accepted byte starts a new frame.
- States:
  - FILL: packing bytes.
  - DROP: discarding the tail of a truncated frame.
- Byte counter: 11 bits, counts accepted bytes in the current frame.
- Lane index: 2 bits; lane 0 = [31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0].
- FILL, rx_valid=1: write rx_byte into the current lane, increment lane index and byte counter.
- Word emission happens when the byte just accepted:
  - fills lane 3, or
  - has rx_last=1, or
  - makes the byte counter equal MAX_BYTES.
- On emission, the word appears on packet4_byte on the next cycle with data_valid=1 (latency 1 clock from the completing byte).
- Unfilled lanes of an emitted word are 0.
- keep on the emitted word is a thermometer from the LSB by byte count n: 1 = 0001, 2 = 0011, 3 = 0111, 4 = 1111. Non-last words are always 1111.
- Frame end when rx_last=1:
  - last_valid=1 with the word.
  - frame_cnt increments.
  - frame_runt=1 if total bytes < MIN_BYTES.
  - Lane index and byte counter clear.
- Counter reaches MAX_BYTES with rx_last=0:
  - Emit the word with last_valid=1 and frame_trunc=1; frame_cnt increments.
  - Go to DROP; lane index and counter clear.
- rx_last on exactly the MAX_BYTES-th byte is a normal end: no truncation, no DROP.
- DROP: accepted bytes are discarded, no output. rx_valid&rx_last returns to FILL. The byte after that starts a new frame.
- rx_valid=0: nothing accepted, state held, data_valid=0. Gaps in the input stream are arbitrary. rx_last without rx_valid is ignored.
- data_valid, last_valid, frame_trunc and frame_runt are single-cycle pulses.
  - packet4_byte and keep hold their last value between pulses.
  - Consecutive emissions are at least one cycle apart, except a 1-byte last word directly after a full word; back-to-back pulses are legal.
- Back-to-back frames: rx_last on cycle t and the first byte of the next frame on t+1 are both handled. The new frame starts at lane 0.

Test Plan:
1. Bytes 01..06 consecutive, rx_last on 06 ->
   - word 0x01020304, keep 1111, last_valid 0;
   - then word 0x05060000, keep 0011, last_valid 1, frame_runt 1;
   - frame_cnt = 1.
2. 64-byte frame 00..3F with rx_valid toggling every other cycle -> 16 words, last word 0x3C3D3E3F keep 1111 last_valid 1, no runt/trunc, each data_valid exactly 1 clock after the 4th byte of the group.
3. MAX_BYTES=8, 10-byte frame 11..1A ->
   - words 0x11121314 and 0x15161718, the second with last_valid 1 and frame_trunc 1;
   - 0x19 and 0x1A produce no output; frame_cnt +1;
   - next frame starts cleanly.
4. MAX_BYTES=8, exactly 8 bytes with rx_last on 8th -> second word keep 1111, last_valid 1, frame_trunc 0, no DROP.
5. 15-byte frame (AA x15) then, next cycle, a 3-byte frame 01 02 03 ->
   - last word of first frame 0xAAAAAA00 keep 0111, no runt;
   - second frame 0x01020300 keep 0111, frame_runt 1;
   - frame_cnt = 2.
6. Assert rst low after 5 bytes of a frame, release, send 16-byte frame -> no output from the aborted bytes, all outputs 0 during reset, new frame emits 4 words from lane 0, frame_cnt = 1.
